// File: rtl/uart_receiver.sv
// UART 8N1 receiver: 2-flop synchronizer, bit-centre sampling, one-byte output register.
// Emits one-cycle rx_ready or ferr pulses and rejects glitched start bits.
module uart_receiver #(
   parameter int unsigned CLK_PER_HALF_BIT = 434
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rxd,
   output logic       rx_ready,
   output logic [7:0] rdata,
   output logic       ferr,
   output logic       rx_busy
);

   localparam int unsigned BitClks = 2 * CLK_PER_HALF_BIT;
   localparam int unsigned TimerW  = $clog2(BitClks);
   localparam logic [TimerW-1:0] HalfEnd = TimerW'(CLK_PER_HALF_BIT - 1);
   localparam logic [TimerW-1:0] BitEnd  = TimerW'(BitClks - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StWaitHigh
   } state_t;

   logic              rx_meta;
   logic              rxs;
   state_t            state;
   logic [TimerW-1:0] timer;
   logic [2:0]        idx;
   logic [7:0]        shift;

   // Synchronizer idles high so reset never looks like a start bit.
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rxd;
         rxs     <= rx_meta;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= StIdle;
         timer    <= '0;
         idx      <= '0;
         shift    <= '0;
         rdata    <= 8'h00;
         rx_ready <= 1'b0;
         ferr     <= 1'b0;
         rx_busy  <= 1'b0;
      end else begin
         rx_ready <= 1'b0;
         ferr     <= 1'b0;
         case (state)
            StIdle: begin
               if (!rxs) begin
                  state   <= StStart;
                  timer   <= '0;
                  rx_busy <= 1'b1;
               end
            end
            StStart: begin
               if (timer == HalfEnd) begin
                  if (rxs) begin
                     state   <= StIdle;
                     rx_busy <= 1'b0;
                  end else begin
                     state <= StData;
                     timer <= '0;
                     idx   <= '0;
                  end
               end else begin
                  timer <= timer + TimerW'(1);
               end
            end
            StData: begin
               if (timer == BitEnd) begin
                  shift[idx] <= rxs;
                  timer      <= '0;
                  if (idx == 3'd7) begin
                     state <= StStop;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end else begin
                  timer <= timer + TimerW'(1);
               end
            end
            StStop: begin
               // Leaving at mid stop bit leaves half a bit to catch a back-to-back start.
               if (timer == BitEnd) begin
                  timer <= '0;
                  if (rxs) begin
                     rdata    <= shift;
                     rx_ready <= 1'b1;
                     state    <= StIdle;
                     rx_busy  <= 1'b0;
                  end else begin
                     ferr  <= 1'b1;
                     state <= StWaitHigh;
                  end
               end else begin
                  timer <= timer + TimerW'(1);
               end
            end
            StWaitHigh: begin
               if (rxs) begin
                  state   <= StIdle;
                  rx_busy <= 1'b0;
               end
            end
            default: begin
               state   <= StIdle;
               rx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
